// File: rtl/ahb_spi_pkg.sv
// Shared register map, status bit positions and engine state encoding for ahb_spi.
package ahb_spi_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_SSEL   = 2'd1,
    REG_TXDATA = 2'd2,
    REG_RXDATA = 2'd3
  } reg_idx_e;

  localparam int unsigned RXFULL_BIT = 0;
  localparam int unsigned TXDONE_BIT = 4;
  localparam int unsigned BUSY_BIT   = 5;
  localparam int unsigned SSINV_BIT  = 6;
  localparam int unsigned NBYTES_LSB = 12;
  localparam int unsigned NBYTES_MSB = 14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/ahb_spi_shift_engine.sv
// SPI mode-0 shift engine: SCLK divider, MSB-first TX/RX shifting, byte counting
// and the one-cycle done/full pulses.
module spi_shift_engine
  import ahb_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] tx_word_i,
  input  logic [2:0]  nbytes_i,
  input  logic        miso_i,
  input  logic        rx_clr_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        full_o,
  output logic [31:0] rx_word_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic [31:0]      tx_sh_q, tx_sh_d;
  logic [5:0]       bits_q, bits_d;
  logic [31:0]      rx_sh_q, rx_sh_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [1:0]       rx_byte_q, rx_byte_d;
  logic [31:0]      rx_word_q, rx_word_d;
  logic [5:0]       nbits;
  logic             byte_done;

  assign nbits = {nbytes_i, 3'b000};

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    tx_sh_d   = tx_sh_q;
    bits_d    = bits_q;
    rx_sh_d   = rx_sh_q;
    rx_bit_d  = rx_bit_q;
    rx_byte_d = rx_byte_q;
    rx_word_d = rx_word_q;
    done_o    = 1'b0;
    full_o    = 1'b0;
    byte_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          sclk_d  = 1'b0;
          // Left-align the frame so the first bit is on MOSI straight away.
          tx_sh_d = tx_word_i << (6'd32 - nbits);
          bits_d  = nbits;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_sh_d   = {rx_sh_q[30:0], miso_i};
            rx_bit_d  = rx_bit_q + 3'd1;
            byte_done = (rx_bit_q == 3'd7);
          end else begin
            tx_sh_d = tx_sh_q << 1;
            if (bits_q == 6'd1) begin
              state_d = ST_IDLE;
              done_o  = 1'b1;
            end else begin
              bits_d = bits_q - 6'd1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing 4th byte beats a simultaneous RXDATA read.
    if (byte_done && rx_byte_q == 2'd3) begin
      full_o    = 1'b1;
      rx_word_d = rx_sh_d;
      rx_byte_d = '0;
    end else if (byte_done) begin
      rx_byte_d = (rx_clr_i ? 2'd0 : rx_byte_q) + 2'd1;
    end else if (rx_clr_i) begin
      rx_byte_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      tx_sh_q   <= '0;
      bits_q    <= '0;
      rx_sh_q   <= '0;
      rx_bit_q  <= '0;
      rx_byte_q <= '0;
      rx_word_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      tx_sh_q   <= tx_sh_d;
      bits_q    <= bits_d;
      rx_sh_q   <= rx_sh_d;
      rx_bit_q  <= rx_bit_d;
      rx_byte_q <= rx_byte_d;
      rx_word_q <= rx_word_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_sh_q[31];
  assign busy_o    = (state_q == ST_SHIFT);
  assign rx_word_o = rx_word_q;

endmodule

// File: rtl/ahb_spi.sv
// AHB-Lite slave exposing a single-master SPI port with 32 software-driven slave selects.
module ahb_spi
  import ahb_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        SPI_MISO_i,
  output logic        SPI_MOSI_o,
  output logic [31:0] SPI_SS_o,
  output logic        SPI_CLK_o
);

  reg_idx_e    addr_q;
  logic        write_q, valid_q;
  logic        ss_inv_q, ss_inv_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] ssel_q, ssel_d;
  logic        rx_full_q, rx_full_d;
  logic        tx_done_q, tx_done_d;

  logic        wr_en, rd_en, start, rx_rd;
  logic        busy, done, full;
  logic [2:0]  nbytes_eff;
  logic [31:0] rx_word;
  logic        unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= REG_CTRL;
    end else if (HREADY) begin
      valid_q <= HSEL & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= reg_idx_e'(HADDR[3:2]);
    end
  end

  assign wr_en      = valid_q & write_q;
  assign rd_en      = valid_q & ~write_q;
  assign start      = wr_en && (addr_q == REG_TXDATA) && !busy;
  assign rx_rd      = rd_en && (addr_q == REG_RXDATA);
  assign nbytes_eff = (nbytes_q == 3'd0) ? 3'd4 : nbytes_q;

  always_comb begin
    ss_inv_d  = ss_inv_q;
    nbytes_d  = nbytes_q;
    ssel_d    = ssel_q;
    tx_done_d = tx_done_q;
    rx_full_d = rx_full_q;
    if (wr_en && addr_q == REG_CTRL) begin
      ss_inv_d = HWDATA[SSINV_BIT];
      nbytes_d = HWDATA[NBYTES_MSB:NBYTES_LSB];
    end
    if (wr_en && addr_q == REG_SSEL) ssel_d = HWDATA;
    if (start || rx_rd) tx_done_d = 1'b0;
    if (done)           tx_done_d = 1'b1;
    if (rx_rd)          rx_full_d = 1'b0;
    if (full)           rx_full_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ss_inv_q  <= 1'b1;
      nbytes_q  <= 3'd4;
      ssel_q    <= '0;
      tx_done_q <= 1'b0;
      rx_full_q <= 1'b0;
    end else begin
      ss_inv_q  <= ss_inv_d;
      nbytes_q  <= nbytes_d;
      ssel_q    <= ssel_d;
      tx_done_q <= tx_done_d;
      rx_full_q <= rx_full_d;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (addr_q)
        REG_CTRL: begin
          HRDATA[RXFULL_BIT]            = rx_full_q;
          HRDATA[TXDONE_BIT]            = tx_done_q;
          HRDATA[BUSY_BIT]              = busy;
          HRDATA[SSINV_BIT]             = ss_inv_q;
          HRDATA[NBYTES_MSB:NBYTES_LSB] = nbytes_q;
        end
        REG_SSEL:   HRDATA = ssel_q;
        REG_RXDATA: HRDATA = rx_word;
        default:    HRDATA = '0;
      endcase
    end
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .start_i   (start),
    .tx_word_i (HWDATA),
    .nbytes_i  (nbytes_eff),
    .miso_i    (SPI_MISO_i),
    .rx_clr_i  (rx_rd),
    .sclk_o    (SPI_CLK_o),
    .mosi_o    (SPI_MOSI_o),
    .busy_o    (busy),
    .done_o    (done),
    .full_o    (full),
    .rx_word_o (rx_word)
  );

  assign HREADYOUT = 1'b1;
  assign SPI_SS_o  = ss_inv_q ? ~ssel_q : ssel_q;

endmodule

// File: tb/tb_ahb_spi.sv
// Directed bench for ahb_spi: register access, SS pins, MOSI framing, MISO capture, reset abort.
module tb_ahb_spi;

  localparam int unsigned CLK_DIV = 5;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic        HREADY  = 1'b1;
  logic [31:0] HADDR   = '0;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'b010;
  logic [1:0]  HTRANS  = 2'b00;
  logic [31:0] HWDATA  = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SPI_MISO_i;
  logic        SPI_MOSI_o;
  logic [31:0] SPI_SS_o;
  logic        SPI_CLK_o;

  ahb_spi #(.CLK_DIV(CLK_DIV)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HTRANS     (HTRANS),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .SPI_MISO_i (SPI_MISO_i),
    .SPI_MOSI_o (SPI_MOSI_o),
    .SPI_SS_o   (SPI_SS_o),
    .SPI_CLK_o  (SPI_CLK_o)
  );

  always #5 HCLK = ~HCLK;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // SPI slave model: MOSI captured on SCLK rise, MISO advanced on SCLK fall.
  int unsigned rise_cnt  = 0;
  int unsigned fall_cnt  = 0;
  logic [31:0] mosi_cap  = '0;
  logic [63:0] miso_stream = '0;
  int unsigned fall_base = 0;
  int unsigned miso_idx;
  logic [5:0]  miso_sel;

  always @(posedge SPI_CLK_o) begin
    mosi_cap <= {mosi_cap[30:0], SPI_MOSI_o};
    rise_cnt <= rise_cnt + 1;
  end
  always @(negedge SPI_CLK_o) fall_cnt <= fall_cnt + 1;

  assign miso_idx   = fall_cnt - fall_base;
  assign miso_sel   = 6'(63 - miso_idx);
  assign SPI_MISO_i = (miso_idx < 64) ? miso_stream[miso_sel] : 1'b0;

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h5200_0000 | {28'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h5200_0000 | {28'h0, a};
    @(posedge HCLK); #1;
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned cycles,
                           output int unsigned busy_lo, output logic [31:0] s);
    cycles  = 0;
    busy_lo = 0;
    do begin
      bus_read(4'h0, s);
      cycles++;
      if (!s[4] && !s[5]) busy_lo++;
    end while (!s[4] && cycles < budget);
    check_eq("tx_done_seen", {31'b0, s[4]}, 32'h1);
  endtask

  initial begin
    logic [31:0] r;
    int unsigned cyc, blo, r0;

    repeat (3) @(posedge HCLK);
    #1;
    check_eq("rst_hrdata", HRDATA, 32'h0);
    check_eq("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check_eq("rst_sclk", {31'b0, SPI_CLK_o}, 32'h0);
    check_eq("rst_mosi", {31'b0, SPI_MOSI_o}, 32'h0);
    check_eq("rst_ss", SPI_SS_o, 32'hFFFF_FFFF);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    bus_read(4'h0, r); check_eq("ctrl_rst", r, 32'h0000_4040);
    bus_read(4'h4, r); check_eq("ssel_rst", r, 32'h0);
    bus_read(4'h8, r); check_eq("txdata_rd", r, 32'h0);

    bus_write(4'h0, 32'h0000_2040);
    bus_read(4'h0, r); check_eq("ctrl_wr", r, 32'h0000_2040);
    bus_write(4'h4, 32'h1);
    check_eq("ss_sel0", SPI_SS_o, 32'hFFFF_FFFE);
    bus_read(4'h4, r); check_eq("ssel_rd", r, 32'h1);

    // IDLE transfer must not write SSEL
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h5200_0004;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'hFFFF_0000;
    @(posedge HCLK); #1;
    check_eq("idle_no_write", SPI_SS_o, 32'hFFFF_FFFE);

    bus_write(4'h0, 32'h0000_2000);
    check_eq("ss_noinv", SPI_SS_o, 32'h0000_0001);
    bus_write(4'h0, 32'h0000_2040);
    bus_write(4'h4, 32'h0);
    check_eq("ss_none", SPI_SS_o, 32'hFFFF_FFFF);

    // Frame 1: 0x1308, 2 bytes, exact duration
    r0 = rise_cnt;
    bus_write(4'h8, 32'h0000_1308);
    wait_done(200, cyc, blo, r);
    check_eq("f1_cycles", cyc, 32'd160);
    check_eq("f1_busy_held", blo, 32'd0);
    check_eq("f1_status", r, 32'h0000_2050);
    check_eq("f1_pulses", rise_cnt - r0, 32'd16);
    check_eq("f1_mosi", {16'h0, mosi_cap[15:0]}, 32'h0000_1308);
    check_eq("f1_sclk_idle", {31'b0, SPI_CLK_o}, 32'h0);

    // Frame 2: 0x1102 with an ignored write while busy
    r0 = rise_cnt;
    bus_write(4'h8, 32'h0000_1102);
    repeat (20) @(posedge HCLK);
    #1;
    bus_write(4'h8, 32'h0000_FFFF);
    wait_done(200, cyc, blo, r);
    check_eq("f2_status", r, 32'h0000_2051);
    check_eq("f2_pulses", rise_cnt - r0, 32'd16);
    check_eq("f2_mosi", {16'h0, mosi_cap[15:0]}, 32'h0000_1102);
    bus_read(4'hC, r); check_eq("rx_zero", r, 32'h0);
    bus_read(4'h0, r); check_eq("rx_clr_status", r, 32'h0000_2040);

    // MISO stream 01 02 | 03 04 over two 2-byte frames
    miso_stream = 64'h0102_0304_0506_0708;
    fall_base   = fall_cnt;
    bus_write(4'h8, 32'h0000_00AB);
    wait_done(200, cyc, blo, r);
    check_eq("f3_status", r, 32'h0000_2050);
    bus_write(4'h8, 32'h0000_00CD);
    wait_done(200, cyc, blo, r);
    check_eq("f4_status", r, 32'h0000_2051);
    bus_read(4'hC, r); check_eq("rx_word1", r, 32'h0102_0304);
    bus_read(4'h0, r); check_eq("rx_rd_clears", r, 32'h0000_2040);

    // nbytes=0 behaves as 4 bytes
    bus_write(4'h0, 32'h0000_0040);
    bus_read(4'h0, r); check_eq("ctrl_nb0", r, 32'h0000_0040);
    r0 = rise_cnt;
    bus_write(4'h8, 32'hA5C3_0F81);
    wait_done(400, cyc, blo, r);
    check_eq("f5_cycles", cyc, 32'd320);
    check_eq("f5_status", r, 32'h0000_0051);
    check_eq("f5_pulses", rise_cnt - r0, 32'd32);
    check_eq("f5_mosi", mosi_cap, 32'hA5C3_0F81);
    bus_read(4'hC, r); check_eq("rx_word2", r, 32'h0506_0708);

    // Reset mid-transfer
    bus_write(4'h4, 32'h1);
    check_eq("ss_pre_rst", SPI_SS_o, 32'hFFFF_FFFE);
    bus_write(4'h8, 32'h0000_0055);
    cyc = 0;
    while (!SPI_CLK_o && cyc < 50) begin
      @(posedge HCLK); #1;
      cyc++;
    end
    check_eq("sclk_hi_seen", {31'b0, SPI_CLK_o}, 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_eq("abort_sclk", {31'b0, SPI_CLK_o}, 32'h0);
    check_eq("abort_ss", SPI_SS_o, 32'hFFFF_FFFF);
    check_eq("abort_mosi", {31'b0, SPI_MOSI_o}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    bus_read(4'h0, r); check_eq("post_rst_status", r, 32'h0000_4040);
    bus_read(4'h4, r); check_eq("post_rst_ssel", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=0x%08h exp=0x%08h", total, 32'h0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_spi.md
# ahb_spi

AHB-Lite slave that provides a single-master SPI port with up to 32 slave-select lines. Software configures a control register, selects a slave, and writes 1–4 bytes for transmission. It then polls a status bit for completion and reads back 32 bits of received MISO data. The block sits on the system AHB-Lite bus (at 0x5200_0000 in the system map; it decodes only HADDR[3:2]) and drives off-chip SPI devices such as the Nexys4 display controller (slave 0).

## Interface
- CLK_DIV, 5: SCLK half-period in HCLK cycles; 50 MHz HCLK gives 5 MHz SCLK. Must be ≥ 1.
- HCLK  in  1  bus clock; only clock in the block.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready; an address phase is accepted only when HREADY is high.
- HADDR  in  32  address; bits [3:2] select the register.
- HWRITE  in  1  write transfer.
- HSIZE  in  3  transfer size; ignored, the full HWDATA word is always captured.
- HTRANS  in  2  transfer type; only bit 1 is used.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied to 1 (zero wait states).
- SPI_MISO_i  in  1  serial data in.
- SPI_MOSI_o  out  1  serial data out.
- SPI_SS_o  out  32  slave selects on the pins.
- SPI_CLK_o  out  1  SCLK.

## Operation
- Address phase: when HSEL & HTRANS[1] & HREADY, latch HADDR[3:2] and HWRITE. The data phase then acts on the latched values.
- 0x0 CTRL/STATUS (R/W):
  - [0] rx_full (RO).
  - [4] tx_done (RO).
  - [5] busy (RO).
  - [6] ss_invert (RW).
  - [14:12] nbytes (RW; 1–4, value 0 is treated as 4).
  - Writes update only the RW fields. Reset value reads 0x0000_4040.
- 0x4 SSEL (R/W): 32-bit one-hot slave mask. SPI_SS_o = ss_invert ? ~SSEL : SSEL. Reset value 0, so all pins are high.
- 0x8 TXDATA (W):
  - When not busy, the write loads the low nbytes bytes, clears tx_done, sets busy and starts the transfer.
  - Bytes are sent from byte nbytes-1 down to byte 0, MSB first. Example: 0x1308 with nbytes=2 sends 0x13, then 0x08.
  - A write while busy is ignored. Reads of this register return 0.
- 0xC RXDATA (R): returns the latched 32-bit receive word and clears rx_full, tx_done and the receive byte counter. Writes are ignored.
- SPI mode 0: SCLK idles low. MOSI changes on SCLK falling edges, and the first bit is driven at start. MISO is sampled on SCLK rising edges.
- Receive:
  - Every sampled bit is shifted into a 32-bit shift register, MSB first.
  - A byte counter increments per 8 bits. When it reaches 4, the shift register is copied to RXDATA, rx_full is set and the counter resets.
  - If rx_full is already set, RXDATA is overwritten and rx_full stays set.
- The SS pins are software-controlled only. The block never toggles them.
- Unmapped and IDLE transfers have no effect.

## Timing
- Reset values: HRDATA 0, HREADYOUT 1, SPI_CLK_o 0, SPI_MOSI_o 0, SPI_SS_o 0xFFFF_FFFF, all flags 0.
- Register writes take effect at the HCLK edge ending the data phase.
- HRDATA is combinational from the latched address in the data phase. A status read in the data phase reflects the state at that edge.
- Transfer shift engine (IDLE → SHIFT → IDLE):
  - Bit period is 2·CLK_DIV HCLK cycles. The transfer lasts nbytes·16·CLK_DIV cycles (nbytes=2, CLK_DIV=5: 160 cycles).
  - On the final falling edge, SCLK returns low, busy clears and tx_done sets in the same cycle.
  - tx_done stays set until the next TXDATA write or RXDATA read.
- Simultaneous events:
  - RXDATA read in the same cycle as the 4th byte completing: the set wins.
  - TXDATA write in the same cycle as transfer end: the write is ignored.
- Reset mid-transfer aborts immediately to reset values.

## Structure
- Shared package ahb_spi_pkg holds:
  - Register offsets: CTRL=0, SSEL=1, TXDATA=2, RXDATA=3 (word index).
  - Status bit positions: RXFULL=0, TXDONE=4, BUSY=5, SSINV=6, NBYTES=14:12.
- One sub-module, spi_shift_engine, contains the clock divider, bit/byte counters, TX/RX shift registers and the done/full pulses. The AHB register file and read mux stay in the top level.

## Test plan
- Reset → CTRL reads 0x0000_4040, SSEL reads 0, SPI_SS_o = 0xFFFF_FFFF, SPI_CLK_o = 0.
- Write CTRL 0x2040, then SSEL 0x1 → SPI_SS_o = 0xFFFF_FFFE. Write SSEL 0 → all ones.
- Write TXDATA 0x1308 → MOSI carries 0x13 then 0x08, MSB first, over 16 SCLK pulses. busy stays high, and status bit 4 rises after 160 HCLK cycles.
- A TXDATA write while busy has no effect on the MOSI stream. The next write after tx_done starts a new 2-byte frame (e.g. 0x1102 sends 0x11, 0x02).
- MISO driven with the stream 01 02 03 04 05 06 07 08 over two 2-byte frames (nbytes=2) → rx_full sets after 4 bytes and RXDATA reads 0x01020304. The read clears status bits 0 and 4.
- Assert reset mid-transfer → SCLK low and SS all ones immediately. A status read after reset shows busy=0 and tx_done=0.
